// File: rtl/hockey_disp_pkg.sv
// Shared constants and types for the hockey display renderer.
package hockey_disp_pkg;

  localparam int ROWS   = 5;
  localparam int COLS   = 8;
  localparam int DIGITS = 4;

  localparam logic [2:0] NO_PUCK_Y = 3'd7;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIG_SCORE_B = 2'd0,
    DIG_DASH    = 2'd1,
    DIG_SCORE_A = 2'd2,
    DIG_BLANK   = 2'd3
  } digit_e;

  typedef enum logic [1:0] {
    SEG_SEL_VAL   = 2'd0,
    SEG_SEL_DASH  = 2'd1,
    SEG_SEL_BLANK = 2'd2
  } seg_sel_e;

  function automatic logic [ROWS-1:0] row_onehot(input logic [2:0] row);
    row_onehot = 5'b00001 << row;
  endfunction

endpackage

// File: rtl/hockey_seg_decode.sv
// Combinational score/dash/blank to active-low {g,f,e,d,c,b,a} segment decoder.
module hockey_seg_decode
  import hockey_disp_pkg::*;
(
  input  seg_sel_e   sel_i,
  input  logic [1:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (sel_i)
      SEG_SEL_VAL: begin
        case (val_i)
          2'd0:    seg_o = 7'b1000000;
          2'd1:    seg_o = 7'b1111001;
          2'd2:    seg_o = 7'b0100100;
          2'd3:    seg_o = 7'b0110000;
          default: seg_o = SEG_BLANK;
        endcase
      end
      SEG_SEL_DASH:  seg_o = SEG_DASH;
      SEG_SEL_BLANK: seg_o = SEG_BLANK;
      default:       seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hockey_display.sv
// Hockey display: frame-latched 8x5 LED matrix scan with goal flash, plus 4-digit score scan.
// Optional macro GUARD_BLANK_EN darkens matrix and digits for BLANK_CYC clocks after every tick.
module hockey_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int FLASH_FRAMES = 8,
  parameter int BLANK_CYC    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] x_coord,
  input  logic [2:0] y_coord,
  input  logic [1:0] score_a,
  input  logic [1:0] score_b,
  input  logic       goal_a,
  input  logic       goal_b,
  output logic [4:0] row_sel,
  output logic [7:0] col_data,
  output logic [3:0] an,
  output logic [6:0] seg
);
  import hockey_disp_pkg::*;

  localparam int PW         = $clog2(SCAN_DIV);
  localparam int FLASH_LOAD = 2 * FLASH_FRAMES;
  localparam int FW         = $clog2(FLASH_LOAD + 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [2:0]        row_q, row_d;
  digit_e            digit_q, digit_d;
  logic [FW-1:0]     flash_q, flash_d;
  logic [2:0]        x_lat_q, x_lat_d;
  logic [2:0]        y_lat_q, y_lat_d;
  logic [1:0]        sa_lat_q, sa_lat_d;
  logic [1:0]        sb_lat_q, sb_lat_d;

  logic              tick_s;
  logic              frame_s;

  logic [ROWS-1:0]   row_sel_s;
  logic [COLS-1:0]   col_s;
  logic [DIGITS-1:0] an_s;
  logic [6:0]        seg_s;
  seg_sel_e          seg_sel_s;
  logic [1:0]        seg_val_s;

  logic [ROWS-1:0]   row_sel_q, row_sel_d;
  logic [COLS-1:0]   col_q, col_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  // Scan timing, frame latch and flash counter next-state.
  always_comb begin
    tick_s   = (presc_q == PW'(SCAN_DIV - 1));
    frame_s  = tick_s && (row_q == 3'(ROWS - 1));
    presc_d  = presc_q + {{(PW-1){1'b0}}, 1'b1};
    row_d    = row_q;
    digit_d  = digit_q;
    x_lat_d  = x_lat_q;
    y_lat_d  = y_lat_q;
    sa_lat_d = sa_lat_q;
    sb_lat_d = sb_lat_q;
    flash_d  = flash_q;

    if (tick_s) begin
      presc_d = {PW{1'b0}};
      digit_d = digit_e'(2'(digit_q) + 2'd1);
      if (row_q == 3'(ROWS - 1)) begin
        row_d = 3'd0;
      end else begin
        row_d = row_q + 3'd1;
      end
    end else begin
      row_d = row_q;
    end

    if (frame_s) begin
      x_lat_d  = x_coord;
      y_lat_d  = y_coord;
      sa_lat_d = score_a;
      sb_lat_d = score_b;
    end else begin
      x_lat_d  = x_lat_q;
    end

    // A goal reload takes priority over the frame-boundary decrement.
    if (goal_a || goal_b) begin
      flash_d = FW'(FLASH_LOAD);
    end else if (frame_s && (flash_q != {FW{1'b0}})) begin
      flash_d = flash_q - {{(FW-1){1'b0}}, 1'b1};
    end else begin
      flash_d = flash_q;
    end
  end

  // Picture for the current row/digit; it is captured into the output registers on the tick.
  always_comb begin
    row_sel_s = row_onehot(row_q);
    col_s     = {COLS{1'b0}};
    an_s      = ~(4'b0001 << 2'(digit_q));
    seg_sel_s = SEG_SEL_BLANK;
    seg_val_s = 2'd0;

    // row_q never exceeds 4, so a latched y of 5..7 never matches a row.
    if (flash_q != {FW{1'b0}}) begin
      col_s = flash_q[0] ? 8'hFF : 8'h00;
    end else if (y_lat_q == row_q) begin
      col_s = 8'b00000001 << x_lat_q;
    end else begin
      col_s = 8'h00;
    end

    case (digit_q)
      DIG_SCORE_B: begin
        seg_sel_s = SEG_SEL_VAL;
        seg_val_s = sb_lat_q;
      end
      DIG_DASH:    seg_sel_s = SEG_SEL_DASH;
      DIG_SCORE_A: begin
        seg_sel_s = SEG_SEL_VAL;
        seg_val_s = sa_lat_q;
      end
      DIG_BLANK:   seg_sel_s = SEG_SEL_BLANK;
      default:     seg_sel_s = SEG_SEL_BLANK;
    endcase
  end

  hockey_seg_decode u_seg_decode (
    .sel_i (seg_sel_s),
    .val_i (seg_val_s),
    .seg_o (seg_s)
  );

`ifdef GUARD_BLANK_EN
  logic [ROWS-1:0]   pend_row_sel_q, pend_row_sel_d;
  logic [COLS-1:0]   pend_col_q, pend_col_d;
  logic [DIGITS-1:0] pend_an_q, pend_an_d;

  // On the tick the picture is parked while outputs stay dark; it is revealed at prescaler==BLANK_CYC.
  always_comb begin
    row_sel_d      = row_sel_q;
    col_d          = col_q;
    an_d           = an_q;
    seg_d          = seg_q;
    pend_row_sel_d = pend_row_sel_q;
    pend_col_d     = pend_col_q;
    pend_an_d      = pend_an_q;
    if (tick_s) begin
      pend_row_sel_d = row_sel_s;
      pend_col_d     = col_s;
      pend_an_d      = an_s;
      row_sel_d      = {ROWS{1'b0}};
      col_d          = {COLS{1'b0}};
      an_d           = {DIGITS{1'b1}};
      seg_d          = seg_s;
    end else if (presc_q == PW'(BLANK_CYC - 1)) begin
      row_sel_d = pend_row_sel_q;
      col_d     = pend_col_q;
      an_d      = pend_an_q;
    end else begin
      seg_d = seg_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_row_sel_q <= {ROWS{1'b0}};
      pend_col_q     <= {COLS{1'b0}};
      pend_an_q      <= {DIGITS{1'b1}};
    end else begin
      pend_row_sel_q <= pend_row_sel_d;
      pend_col_q     <= pend_col_d;
      pend_an_q      <= pend_an_d;
    end
  end
`else
  logic unused_blank_cyc_s;
  assign unused_blank_cyc_s = (BLANK_CYC < 0);

  // Outputs take the new picture on the tick and hold in between.
  always_comb begin
    row_sel_d = row_sel_q;
    col_d     = col_q;
    an_d      = an_q;
    seg_d     = seg_q;
    if (tick_s) begin
      row_sel_d = row_sel_s;
      col_d     = col_s;
      an_d      = an_s;
      seg_d     = seg_s;
    end else begin
      seg_d = seg_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= {PW{1'b0}};
      row_q     <= 3'd0;
      digit_q   <= DIG_SCORE_B;
      flash_q   <= {FW{1'b0}};
      x_lat_q   <= 3'd0;
      y_lat_q   <= NO_PUCK_Y;
      sa_lat_q  <= 2'd0;
      sb_lat_q  <= 2'd0;
      row_sel_q <= {ROWS{1'b0}};
      col_q     <= {COLS{1'b0}};
      an_q      <= {DIGITS{1'b1}};
      seg_q     <= SEG_BLANK;
    end else begin
      presc_q   <= presc_d;
      row_q     <= row_d;
      digit_q   <= digit_d;
      flash_q   <= flash_d;
      x_lat_q   <= x_lat_d;
      y_lat_q   <= y_lat_d;
      sa_lat_q  <= sa_lat_d;
      sb_lat_q  <= sb_lat_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign row_sel  = row_sel_q;
  assign col_data = col_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_hockey_display.sv
// Directed, table-driven bench for hockey_display with SCAN_DIV=4 and FLASH_FRAMES=2.
module tb_hockey_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] x_coord, y_coord;
  logic [1:0] score_a, score_b;
  logic       goal_a, goal_b;
  logic [4:0] row_sel;
  logic [7:0] col_data;
  logic [3:0] an;
  logic [6:0] seg;

  int n_vec = 0;
  int n_err = 0;

  hockey_display #(
    .SCAN_DIV     (SD),
    .FLASH_FRAMES (2),
    .BLANK_CYC    (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .x_coord  (x_coord),
    .y_coord  (y_coord),
    .score_a  (score_a),
    .score_b  (score_b),
    .goal_a   (goal_a),
    .goal_b   (goal_b),
    .row_sel  (row_sel),
    .col_data (col_data),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
    logic [4:0] rs;
    logic [7:0] col;
    logic [3:0] an;
    logic [6:0] seg;
  } vec_t;

  typedef struct {
    bit ga;
    bit gb;
    bit gend;
    int mode;  // 0 normal puck, 1 all on, 2 all off
  } fr_t;

  vec_t tbl[25];
  fr_t  frs[14];

  function automatic vec_t mk(input logic [2:0] x, input logic [2:0] y, input logic [4:0] rs,
                              input logic [7:0] col, input logic [3:0] a, input logic [6:0] s);
    vec_t v;
    v.x = x; v.y = y; v.rs = rs; v.col = col; v.an = a; v.seg = s;
    return v;
  endfunction

  function automatic fr_t mf(input bit ga, input bit gb, input bit gend, input int mode);
    fr_t f;
    f.ga = ga; f.gb = gb; f.gend = gend; f.mode = mode;
    return f;
  endfunction

  task automatic check(input string name, input logic [4:0] e_rs, input logic [7:0] e_col,
                       input logic [3:0] e_an, input logic [6:0] e_seg, input bit dig);
    n_vec++;
    if (row_sel !== e_rs || col_data !== e_col || (dig && (an !== e_an || seg !== e_seg))) begin
      n_err++;
      $display("FAIL %s: got row_sel=%b col=%h an=%b seg=%b, want row_sel=%b col=%h an=%b seg=%b (digits checked=%0d)",
               name, row_sel, col_data, an, seg, e_rs, e_col, e_an, e_seg, dig);
    end
  endtask

  // One scan slot: SD clock edges, optional goal pulse on clock number gclk (1..SD), sample #1 after the tick edge.
  task automatic run_vec(input bit ga, input bit gb, input int gclk);
    for (int c = 1; c <= SD; c++) begin
      goal_a = ga && (c == gclk);
      goal_b = gb && (c == gclk);
      @(posedge clk);
      #1;
    end
    goal_a = 1'b0;
    goal_b = 1'b0;
  endtask

  initial begin
    // Frame 0 shows reset latches (no puck, scores 0); x/y/scores are latched on each row-4 tick.
    tbl[0]  = mk(3'd3, 3'd2, 5'b00001, 8'h00, 4'b1110, 7'h40);
    tbl[1]  = mk(3'd3, 3'd2, 5'b00010, 8'h00, 4'b1101, 7'h3F);
    tbl[2]  = mk(3'd3, 3'd2, 5'b00100, 8'h00, 4'b1011, 7'h40);
    tbl[3]  = mk(3'd3, 3'd2, 5'b01000, 8'h00, 4'b0111, 7'h7F);
    tbl[4]  = mk(3'd3, 3'd2, 5'b10000, 8'h00, 4'b1110, 7'h40);
    tbl[5]  = mk(3'd3, 3'd2, 5'b00001, 8'h00, 4'b1101, 7'h3F);
    tbl[6]  = mk(3'd6, 3'd2, 5'b00010, 8'h00, 4'b1011, 7'h24);
    tbl[7]  = mk(3'd6, 3'd2, 5'b00100, 8'h08, 4'b0111, 7'h7F);
    tbl[8]  = mk(3'd6, 3'd2, 5'b01000, 8'h00, 4'b1110, 7'h30);
    tbl[9]  = mk(3'd6, 3'd2, 5'b10000, 8'h00, 4'b1101, 7'h3F);
    tbl[10] = mk(3'd6, 3'd2, 5'b00001, 8'h00, 4'b1011, 7'h24);
    tbl[11] = mk(3'd6, 3'd2, 5'b00010, 8'h00, 4'b0111, 7'h7F);
    tbl[12] = mk(3'd6, 3'd2, 5'b00100, 8'h40, 4'b1110, 7'h30);
    tbl[13] = mk(3'd6, 3'd2, 5'b01000, 8'h00, 4'b1101, 7'h3F);
    tbl[14] = mk(3'd6, 3'd5, 5'b10000, 8'h00, 4'b1011, 7'h24);
    tbl[15] = mk(3'd6, 3'd5, 5'b00001, 8'h00, 4'b0111, 7'h7F);
    tbl[16] = mk(3'd6, 3'd5, 5'b00010, 8'h00, 4'b1110, 7'h30);
    tbl[17] = mk(3'd6, 3'd5, 5'b00100, 8'h00, 4'b1101, 7'h3F);
    tbl[18] = mk(3'd6, 3'd5, 5'b01000, 8'h00, 4'b1011, 7'h24);
    tbl[19] = mk(3'd6, 3'd2, 5'b10000, 8'h00, 4'b0111, 7'h7F);
    tbl[20] = mk(3'd6, 3'd2, 5'b00001, 8'h00, 4'b1110, 7'h30);
    tbl[21] = mk(3'd6, 3'd2, 5'b00010, 8'h00, 4'b1101, 7'h3F);
    tbl[22] = mk(3'd6, 3'd2, 5'b00100, 8'h40, 4'b1011, 7'h24);
    tbl[23] = mk(3'd6, 3'd2, 5'b01000, 8'h00, 4'b0111, 7'h7F);
    tbl[24] = mk(3'd6, 3'd2, 5'b10000, 8'h00, 4'b1110, 7'h30);

    // Flash count 4 shows off, 3 on, 2 off, 1 on; gend puts the pulse on the row-4 tick clock.
    frs[0]  = mf(1'b1, 1'b0, 1'b0, 2);
    frs[1]  = mf(1'b0, 1'b0, 1'b0, 1);
    frs[2]  = mf(1'b0, 1'b1, 1'b0, 2);
    frs[3]  = mf(1'b0, 1'b0, 1'b0, 1);
    frs[4]  = mf(1'b0, 1'b0, 1'b0, 2);
    frs[5]  = mf(1'b0, 1'b0, 1'b0, 1);
    frs[6]  = mf(1'b0, 1'b0, 1'b0, 0);
    frs[7]  = mf(1'b1, 1'b1, 1'b0, 2);
    frs[8]  = mf(1'b1, 1'b0, 1'b1, 1);
    frs[9]  = mf(1'b0, 1'b0, 1'b0, 2);
    frs[10] = mf(1'b0, 1'b0, 1'b0, 1);
    frs[11] = mf(1'b0, 1'b0, 1'b0, 2);
    frs[12] = mf(1'b0, 1'b0, 1'b0, 1);
    frs[13] = mf(1'b0, 1'b0, 1'b0, 0);

    rst     = 1'b0;
    x_coord = 3'd3;
    y_coord = 3'd2;
    score_a = 2'd2;
    score_b = 2'd3;
    goal_a  = 1'b0;
    goal_b  = 1'b0;
    #12;
    check("reset", 5'b00000, 8'h00, 4'b1111, 7'h7F, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 25; k++) begin
      x_coord = tbl[k].x;
      y_coord = tbl[k].y;
      run_vec(1'b0, 1'b0, 0);
      check($sformatf("vec%0d", k), tbl[k].rs, tbl[k].col, tbl[k].an, tbl[k].seg, 1'b1);
    end

    for (int f = 0; f < 14; f++) begin
      for (int r = 0; r < 5; r++) begin
        int gclk;
        logic [7:0] ecol;
        logic [4:0] ers;
        gclk = 0;
        if (frs[f].gend && r == 4) gclk = SD;
        if (!frs[f].gend && r == 0) gclk = 1;
        run_vec(frs[f].ga, frs[f].gb, gclk);
        if (frs[f].mode == 1)      ecol = 8'hFF;
        else if (frs[f].mode == 2) ecol = 8'h00;
        else                       ecol = (r == 2) ? 8'h40 : 8'h00;
        ers = 5'b00001 << r;
        check($sformatf("flash f%0d r%0d", f, r), ers, ecol, 4'b1111, 7'h7F, 1'b0);
      end
    end

    // Start a flash, then drop reset part-way through the row-3 slot.
    run_vec(1'b1, 1'b0, 1);
    check("preflash r0", 5'b00001, 8'h00, 4'b1111, 7'h7F, 1'b0);
    run_vec(1'b0, 1'b0, 0);
    check("preflash r1", 5'b00010, 8'h00, 4'b1111, 7'h7F, 1'b0);
    run_vec(1'b0, 1'b0, 0);
    check("preflash r2", 5'b00100, 8'h00, 4'b1111, 7'h7F, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async reset", 5'b00000, 8'h00, 4'b1111, 7'h7F, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (SD - 1) @(posedge clk);
    #1;
    check("hold before first tick", 5'b00000, 8'h00, 4'b1111, 7'h7F, 1'b1);
    @(posedge clk);
    #1;
    check("first tick after reset", 5'b00001, 8'h00, 4'b1110, 7'h40, 1'b1);
    for (int r = 1; r < 5; r++) begin
      run_vec(1'b0, 1'b0, 0);
      check($sformatf("post-reset f0 r%0d", r), 5'b00001 << r, 8'h00, 4'b1111, 7'h7F, 1'b0);
    end
    for (int r = 0; r < 5; r++) begin
      run_vec(1'b0, 1'b0, 0);
      check($sformatf("post-reset f1 r%0d", r), 5'b00001 << r, (r == 2) ? 8'h40 : 8'h00,
            4'b1111, 7'h7F, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
